// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out reads and buffered CPU writes.
// Optional macro VGA_FB_STATS_EN adds a saturating write-stall counter output (stall_cnt).
module vga_fb_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int WFIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              blank_b,
  output logic [PIX_W-1:0]  pix,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [31:0]       cpu_wr_data,
  output logic              cpu_wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
`ifdef VGA_FB_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              underrun
);
  localparam int WA = $clog2(WFIFO_DEPTH);
  localparam int LW = $clog2(PIX_PER_WORD);
  localparam logic [ADDR_W:0] FRAME_WORDS = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE / PIX_PER_WORD);
  logic [ADDR_W:0]   fp;
  logic [31:0]       pbuf [2];
  logic              pb_wp, pb_rp;
  logic [1:0]        pb_cnt;
  logic              rd_v1, rd_v2;
  logic [ADDR_W-1:0] wf_addr [WFIFO_DEPTH];
  logic [31:0]       wf_data [WFIFO_DEPTH];
  logic [WA:0]       wf_wp, wf_rp;
  logic              flush, rd_ok, wf_push, wf_pop, wf_empty, in_range;
  logic              pb_push, pb_pop, pb_empty;
  logic [LW-1:0]     lane;
  logic [31:0]       head;
  logic              unused;
  assign lane         = x[LW-1:0];
  assign unused       = ^x[9:LW];
  assign flush        = y == 10'(V_ACTIVE);
  // rd_v1/rd_v2 track reads still in the 2-cycle RAM pipeline so the buffer can never overflow
  assign rd_ok        = !flush && fp < FRAME_WORDS && ({1'b0, pb_cnt} + {2'b0, rd_v1} + {2'b0, rd_v2}) < 3'd2;
  assign wf_empty     = wf_wp == wf_rp;
  assign cpu_wr_ready = (wf_wp - wf_rp) != (WA+1)'(WFIFO_DEPTH);
  assign wf_push      = cpu_wr_valid && cpu_wr_ready;
  assign wf_pop       = !rd_ok && !wf_empty;
  assign in_range     = {1'b0, wf_addr[wf_rp[WA-1:0]]} < FRAME_WORDS;
  assign pb_empty     = pb_cnt == 2'd0;
  assign pb_push      = rd_v2 && !flush;
  assign pb_pop       = blank_b && &lane && !pb_empty && !flush;
  assign head         = pbuf[pb_rp];
  always_ff @(posedge clk) begin
    if (wf_push) begin
      wf_addr[wf_wp[WA-1:0]] <= cpu_wr_addr;
      wf_data[wf_wp[WA-1:0]] <= cpu_wr_data;
    end
    if (pb_push) pbuf[pb_wp] <= mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp        <= '0;
      pb_wp     <= 1'b0;
      pb_rp     <= 1'b0;
      pb_cnt    <= 2'd0;
      rd_v1     <= 1'b0;
      rd_v2     <= 1'b0;
      wf_wp     <= '0;
      wf_rp     <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      pix       <= '0;
      underrun  <= 1'b0;
    end else begin
      if (wf_push) wf_wp <= wf_wp + (WA+1)'(1);
      if (wf_pop) wf_rp <= wf_rp + (WA+1)'(1);
      mem_we <= wf_pop && in_range;
      if (rd_ok) mem_addr <= fp[ADDR_W-1:0];
      else if (wf_pop && in_range) begin
        mem_addr  <= wf_addr[wf_rp[WA-1:0]];
        mem_wdata <= wf_data[wf_rp[WA-1:0]];
      end
      fp    <= flush ? '0 : rd_ok ? fp + (ADDR_W+1)'(1) : fp;
      rd_v1 <= rd_ok;
      rd_v2 <= rd_v1 && !flush;
      if (flush) begin
        pb_wp  <= 1'b0;
        pb_rp  <= 1'b0;
        pb_cnt <= 2'd0;
      end else begin
        if (pb_push) pb_wp <= ~pb_wp;
        if (pb_pop) pb_rp <= ~pb_rp;
        pb_cnt <= pb_cnt + {1'b0, pb_push} - {1'b0, pb_pop};
      end
      pix <= (blank_b && !pb_empty) ? head[int'(lane)*PIX_W +: PIX_W] : '0;
      if (blank_b && pb_empty) underrun <= 1'b1;
    end
  end
`ifdef VGA_FB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (cpu_wr_valid && !cpu_wr_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized self-checking bench on a reduced 32x6 raster.
// Pixel reference is the intended image indexed by (y*H + x)/4, lane x%4.
module tb_vga_fb_arbiter;
  localparam int H = 32, V = 6, HT = 40, VT = 9, FW = H * V / 4, AW = 17;
  typedef struct {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, rst_n;
  logic [9:0] x, y;
  logic blank_b;
  logic [7:0] pix;
  logic cpu_wr_valid, cpu_wr_ready, mem_we, underrun;
  logic [AW-1:0] cpu_wr_addr, mem_addr;
  logic [31:0] cpu_wr_data, mem_wdata, mem_rdata;
`ifdef VGA_FB_STATS_EN
  logic [15:0] stall_cnt;
`endif
  logic [31:0] ram [FW];
  logic [31:0] exp_fb [FW];
  logic [7:0] cap [H];
  logic ram_load, rdy_prev, blk_prev, chk_en, saw_low;
  wr_t wq[$], wlog[$], pend[$];
  int hc, vc, px, py, acc_n, stall_m, checks = 0, failures = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .blank_b(blank_b), .pix(pix),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_ready(cpu_wr_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef VGA_FB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .underrun(underrun));

  always @(posedge clk) begin
    if (ram_load) ram <= exp_fb;
    else if (mem_we) begin
      if (mem_addr < AW'(FW)) ram[mem_addr] <= mem_wdata;
      wlog.push_back('{a: mem_addr, d: mem_wdata});
    end
    mem_rdata <= (mem_addr < AW'(FW)) ? ram[mem_addr] : 32'h0;
  end

  task automatic tick();
    logic [31:0] w;
    logic [7:0] e;
    @(negedge clk);
    if (!rst_n) stall_m = 0;
    else if (cpu_wr_valid && !rdy_prev && stall_m < 65535) stall_m++;
    if (rst_n && cpu_wr_valid && rdy_prev) begin
      acc_n++;
      void'(wq.pop_front());
    end
    if (!cpu_wr_ready) saw_low = 1'b1;
    if (blk_prev && py == 0) cap[px] = pix;
    if (chk_en && rst_n) begin
      e = 8'h00;
      if (blk_prev) begin
        w = exp_fb[(py * H + px) / 4];
        e = w[(px % 4) * 8 +: 8];
      end
      checks++;
      if (pix !== e) begin
        failures++;
        $display("FAIL pix x=%0d y=%0d got %h expected %h", px, py, pix, e);
      end
    end
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc = (vc + 1) % VT;
    end
    if (hc == 0 && vc == V) begin
      foreach (pend[i]) exp_fb[pend[i].a] = pend[i].d;
      pend.delete();
      chk_en = 1'b1;
    end
    px = hc;
    py = vc;
    blk_prev = hc < H && vc < V;
    x = 10'(hc);
    y = 10'(vc);
    blank_b = blk_prev;
    cpu_wr_valid = rst_n && wq.size() > 0;
    if (cpu_wr_valid) begin
      cpu_wr_addr = wq[0].a;
      cpu_wr_data = wq[0].d;
    end
    rdy_prev = cpu_wr_ready;
  endtask

  task automatic run_to(input int tx, input int ty);
    int n = 0;
    while (!(hc == tx && vc == ty) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL run_to timeout waiting for x=%0d y=%0d, at x=%0d y=%0d", tx, ty, hc, vc);
    end
  endtask

  task automatic queue_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
  endtask

  task automatic test_reset();
    for (int i = 0; i < FW; i++) exp_fb[i] = $urandom;
    exp_fb[0] = 32'h44332211;
    exp_fb[1] = 32'h88776655;
    rst_n = 1'b0; ram_load = 1'b1; chk_en = 1'b0; saw_low = 1'b0;
    hc = 0; vc = V; px = 0; py = V; blk_prev = 1'b0;
    x = 10'(hc); y = 10'(vc); blank_b = 1'b0;
    cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    acc_n = 0; stall_m = 0;
    #1;
    checks += 6;
    if (pix !== 8'h00) begin failures++; $display("FAIL reset_pix got %h expected 00", pix); end
    if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got %h expected 0", mem_addr); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b expected 0", mem_we); end
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got %h expected 0", mem_wdata); end
    if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got %b expected 0", underrun); end
    if (cpu_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b expected 1", cpu_wr_ready); end
    @(negedge clk);
    ram_load = 1'b0;
    rst_n = 1'b1;
    rdy_prev = cpu_wr_ready;
    chk_en = 1'b1;
  endtask

  task automatic test_wr_idle();
    logic found = 1'b0;
    acc_n = 0;
    wlog.delete();
    queue_wr(AW'(5), 32'hDEADBEEF);
    queue_wr(AW'(FW), 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_we === 1'b1 && mem_addr === AW'(5) && mem_wdata === 32'hDEADBEEF) found = 1'b1;
    end
    exp_fb[5] = 32'hDEADBEEF;
    repeat (6) tick();
    checks += 3;
    if (!found) begin failures++; $display("FAIL wr_idle_issue got mem_we=%b addr=%h data=%h expected 1/5/deadbeef", mem_we, mem_addr, mem_wdata); end
    if (acc_n != 2) begin failures++; $display("FAIL wr_idle_accepted got %0d expected 2", acc_n); end
    if (wlog.size() != 1 || wlog[0].a !== AW'(5)) begin failures++; $display("FAIL wr_oob_dropped got %0d ram writes expected 1 (addr 5 only)", wlog.size()); end
  endtask

  task automatic test_blank_restart();
    run_to(0, V + 1);
    tick();
    checks += 2;
    if (mem_addr !== '0) begin failures++; $display("FAIL restart_mem_addr got %h expected 0", mem_addr); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL restart_mem_we got %b expected 0", mem_we); end
  endtask

  task automatic test_first_line(input string tag);
    logic [7:0] e0 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] e1 [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_to(0, 1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[i] !== e0[i]) begin failures++; $display("FAIL %s_line0 x=%0d got %h expected %h", tag, i, cap[i], e0[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[20 + i] !== e1[i]) begin failures++; $display("FAIL %s_word5 x=%0d got %h expected %h", tag, 20 + i, cap[20 + i], e1[i]); end
    end
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL %s_underrun got %b expected 0", tag, underrun); end
  endtask

  task automatic test_fifo_full();
    wr_t sent[$];
    wr_t w;
    int n = 0;
    run_to(0, 4);
    saw_low = 1'b0;
    wlog.delete();
    for (int i = 0; i < 24; i++) begin
      w.a = AW'(8 + i);
      w.d = $urandom;
      wq.push_back(w);
      sent.push_back(w);
      pend.push_back(w);
    end
    while (wq.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    repeat (16) tick();
    checks += 4;
    if (wq.size() != 0) begin failures++; $display("FAIL fifo_drain got %0d unaccepted expected 0", wq.size()); end
    if (saw_low !== 1'b1) begin failures++; $display("FAIL fifo_backpressure got ready_low=%b expected 1", saw_low); end
    if (wlog.size() != 24) begin failures++; $display("FAIL fifo_write_count got %0d expected 24", wlog.size()); end
    if (underrun !== 1'b0) begin failures++; $display("FAIL fifo_underrun got %b expected 0", underrun); end
    for (int i = 0; i < 24 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].a !== sent[i].a || wlog[i].d !== sent[i].d) begin
        failures++;
        $display("FAIL fifo_order #%0d got %h:%h expected %h:%h", i, wlog[i].a, wlog[i].d, sent[i].a, sent[i].d);
      end
    end
`ifdef VGA_FB_STATS_EN
    checks++;
    if (stall_cnt !== 16'(stall_m)) begin failures++; $display("FAIL stall_cnt got %0d expected %0d", stall_cnt, stall_m); end
`endif
  endtask

  task automatic test_underrun_reset();
    int n = 0;
    run_to(10, 2);
    chk_en = 1'b0;
    rst_n = 1'b0;
    run_to(HT - 1, 2);
    rst_n = 1'b1;
    tick();
    tick();
    checks += 2;
    if (pix !== 8'h00) begin failures++; $display("FAIL starve_pix got %h expected 00", pix); end
    if (underrun !== 1'b1) begin failures++; $display("FAIL starve_underrun got %b expected 1", underrun); end
    for (int i = 0; i < 24; i++) queue_wr(AW'(8 + i), $urandom);
    while (cpu_wr_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (cpu_wr_ready !== 1'b0) begin failures++; $display("FAIL refill_full got ready=%b expected 0", cpu_wr_ready); end
    rst_n = 1'b0;
    wq.delete();
    cpu_wr_valid = 1'b0;
    #1;
    checks += 3;
    if (underrun !== 1'b0) begin failures++; $display("FAIL async_underrun got %b expected 0", underrun); end
    if (cpu_wr_ready !== 1'b1) begin failures++; $display("FAIL async_ready got %b expected 1", cpu_wr_ready); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL async_mem_we got %b expected 0", mem_we); end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_wr_idle();
    test_blank_restart();
    test_first_line("frame1");
    test_fifo_full();
    test_first_line("frame2");
    test_underrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
